// File: rtl/serializer.sv
// serializer: parallel-to-serial shifter with per-word bit count, MSB first by default.
// Define SERIALIZER_LSB_FIRST_EN to shift LSB first instead.
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t            state, state_nx;
    logic [DATA_W-1:0] sh, sh_nx;
    logic [MOD_W:0]    cnt, cnt_nx;
    logic              legal;
    logic [MOD_W:0]    n_load;
    logic              head;
    // Counts 1 and 2 are rejected; 0 stands for a full word.
    assign legal  = (data_mod_i == '0) || (data_mod_i >= MOD_W'(3));
    assign n_load = (data_mod_i == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, data_mod_i};
`ifdef SERIALIZER_LSB_FIRST_EN
    assign head = sh[0];
`else
    assign head = sh[DATA_W-1];
`endif
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (data_val_i && legal) begin
                state_nx = SHIFT;
                sh_nx    = data_i;
                cnt_nx   = n_load;
            end
        end else begin
`ifdef SERIALIZER_LSB_FIRST_EN
            sh_nx  = sh >> 1;
`else
            sh_nx  = sh << 1;
`endif
            cnt_nx = cnt - (MOD_W+1)'(1);
            state_nx = (cnt == (MOD_W+1)'(1)) ? IDLE : SHIFT;
        end
    end
    assign busy_o         = (state == SHIFT);
    assign ser_data_val_o = busy_o;
    assign ser_data_o     = busy_o & head;
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: randomized scoreboard bench for serializer; expected bits are
// queued with their due cycle at request time and a negedge monitor checks them.
module tb_serializer;
    localparam int DW = 16;
    localparam int MW = 4;
`ifdef SERIALIZER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [DW-1:0] data = '0;
    logic [MW-1:0] mod = '0;
    logic          val = 1'b0;
    logic          ser, ser_val, busy;
    typedef struct {int c; logic b;} ent_t;
    ent_t exp_q[$];
    int cyc = 0;
    int free_at = 0;
    int checks = 0;
    int errors = 0;
    serializer #(.DATA_W(DW), .MOD_W(MW)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(data), .data_mod_i(mod),
        .data_val_i(val), .ser_data_o(ser), .ser_data_val_o(ser_val), .busy_o(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Reference: an idle serializer takes a legal request and owes N bits in the following N cycles.
    task automatic req(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic v);
        int n;
        data = d;
        mod  = m;
        val  = v;
        if (v && (m == 0 || m >= 3) && cyc >= free_at) begin
            n = (m == 0) ? DW : int'(m);
            for (int k = 0; k < n; k++)
                exp_q.push_back('{c: cyc + 1 + k, b: LSB ? d[k] : d[DW-1-k]});
            free_at = cyc + n + 1;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(16'($urandom), 4'($urandom), 1'b0);
    endtask
    task automatic chk(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, got, want);
        end
    endtask
    always @(negedge clk) begin
        ent_t e;
        chk("busy_eq_val", busy, ser_val);
        if (ser_val) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bit: cycle %0d got valid bit %b expected no output", cyc, ser);
            end else begin
                e = exp_q.pop_front();
                if (e.c != cyc || e.b !== ser) begin
                    errors++;
                    $display("FAIL bit: cycle %0d bit %b, expected cycle %0d bit %b", cyc, ser, e.c, e.b);
                end
            end
        end else begin
            chk("idle_data_zero", ser, 1'b0);
            if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_bit: cycle %0d got no valid bit expected %b", cyc, e.b);
            end
        end
    end
    initial begin
        logic [MW-1:0] m;
        repeat (3) @(posedge clk);
        #3;
        chk("reset_busy", busy, 1'b0);
        chk("reset_val", ser_val, 1'b0);
        arst_n  = 1'b1;
        free_at = cyc;
        req(16'hA5C3, 4'd0, 1'b1);
        idle(18);
        req(16'hF000, 4'd3, 1'b1);
        idle(5);
        req(16'hFFFF, 4'd1, 1'b1);
        idle(3);
        req(16'hFFFF, 4'd2, 1'b1);
        idle(3);
        // Continuous requests: only those arriving while idle are taken.
        for (int i = 0; i < 80; i++) begin
            m = 4'($urandom_range(0, 15));
            if (m == 1 || m == 2) m = 0;
            req(16'($urandom), m, 1'b1);
        end
        idle(20);
        req(16'hFFFF, 4'd0, 1'b1);
        idle(5);
        #2;
        arst_n = 1'b0;
        #1;
        chk("async_rst_data", ser, 1'b0);
        chk("async_rst_val", ser_val, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        arst_n  = 1'b1;
        free_at = cyc;
        idle(20);
        req(16'h0001, 4'd4, 1'b1);
        idle(6);
        for (int i = 0; i < 400; i++)
            req(16'($urandom), 4'($urandom), ($urandom % 3) == 0);
        idle(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d bits outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
